// File: rtl/pair_max_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pair_max_scan_pkg
// Description : Shared types and derived constants for the pair-max scanner.
//               Holds the controller state type and helpers that turn the
//               RAM depth into pair count and pair-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package pair_max_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Defaults for the standard 16-word RAM.
    localparam int R_DEFAULT = 16;
    localparam int N_PAIRS   = R_DEFAULT / 2;
    localparam int IDX_W     = $clog2(R_DEFAULT) - 1;

    // Per-instance versions of the derived constants for overridden depths.
    function automatic int f_n_pairs(input int depth);
        return depth / 2;
    endfunction

    function automatic int f_idx_w(input int depth);
        return $clog2(depth) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pair_max_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : pair_max_scan_if
// Description : Read bus between the scanner and its input RAM.
//               i   : pair index (selects words 2*i and 2*i+1)
//               po1 : word 2*i, registered in the RAM (one cycle latency)
//               po2 : word 2*i+1, same timing as po1
//               master = scanner side, slave = RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pair_max_scan_if
    import pair_max_scan_pkg::*;
#(
    parameter int r = 16,
    parameter int n = 16
);
    logic [f_idx_w(r)-1:0] i;
    logic [n-1:0]          po1;
    logic [n-1:0]          po2;

    modport master (output i, input po1, input po2);
    modport slave  (input i, output po1, output po2);
endinterface
`default_nettype wire

// File: rtl/pair_max_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pair_scan_ctrl
// Description : Scan controller: IDLE/SCAN/DRAIN/DONE FSM, pair address
//               counter, one-cycle valid/index delay matching RAM latency,
//               and busy/done status.
//   clk, rst  : clock, synchronous active-high reset
//   i_start   : scan request, honoured only in IDLE
//   o_addr    : pair index presented to the RAM
//   o_vld     : RAM data on this cycle belongs to pair o_idx_d
//   o_idx_d   : pair index delayed by one cycle
//   o_busy    : high in SCAN and DRAIN
//   o_done    : high in DONE (one cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module pair_scan_ctrl
    import pair_max_scan_pkg::*;
#(
    parameter int r = 16
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    i_start,
    output logic [f_idx_w(r)-1:0]  o_addr,
    output logic                   o_vld,
    output logic [f_idx_w(r)-1:0]  o_idx_d,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int                  c_IDX_W = f_idx_w(r);
    localparam logic [c_IDX_W-1:0]  c_LAST  = c_IDX_W'(f_n_pairs(r) - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_addr;
    logic [c_IDX_W-1:0]  w_addr_nxt;
    logic [c_IDX_W-1:0]  r_idx_d;
    logic                r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_vld   <= 1'b0;
            r_idx_d <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            // Every SCAN cycle presents one address; its data returns next cycle.
            r_vld   <= (r_state == SCAN);
            r_idx_d <= r_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                o_busy = 1'b1;
                // Leave on the last pair rather than wrapping the counter.
                if (r_addr == c_LAST) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_addr_nxt = r_addr + c_IDX_W'(1);
                end
            end
            DRAIN: begin
                o_busy      = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_addr  = r_addr;
    assign o_vld   = r_vld;
    assign o_idx_d = r_idx_d;

endmodule
`default_nettype wire

// File: rtl/pair_max_scan.sv
`default_nettype none
// ============================================================================
// Module      : pair_max_scan
// Description : Scans all r/2 word pairs of an external registered RAM and
//               reports the largest unsigned pair sum and its pair index.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle scan request (ignored unless idle)
//   ram      : RAM read bus (i out, po1/po2 in)
//   busy     : scan in progress (SCAN through DRAIN)
//   done     : one-cycle pulse when max_sum/max_idx are final
//   max_sum  : largest po1+po2, n+1 bits
//   max_idx  : pair index that produced max_sum
// Revision    : 1.0 - initial release
// ============================================================================
module pair_max_scan
    import pair_max_scan_pkg::*;
#(
    parameter int r = 16,
    parameter int n = 16
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    start,
    pair_max_scan_if.master        ram,
    output logic                   busy,
    output logic                   done,
    output logic [n:0]             max_sum,
    output logic [f_idx_w(r)-1:0]  max_idx
);

    localparam int c_IDX_W = f_idx_w(r);

    logic [c_IDX_W-1:0]  w_addr;
    logic                w_vld;
    logic [c_IDX_W-1:0]  w_idx_d;
    logic [n:0]          w_sum;
    logic [n:0]          r_max_sum;
    logic [c_IDX_W-1:0]  r_max_idx;

    pair_scan_ctrl #(
        .r (r)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .o_addr  (w_addr),
        .o_vld   (w_vld),
        .o_idx_d (w_idx_d),
        .o_busy  (busy),
        .o_done  (done)
    );

    assign ram.i = w_addr;

    // Zero-extend both words so the carry out is kept in the sum.
    assign w_sum = {1'b0, ram.po1} + {1'b0, ram.po2};

    // Pair 0 is always the first pair of a scan, so it loads unconditionally;
    // strict comparison afterwards keeps the earliest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_sum <= '0;
            r_max_idx <= '0;
        end else if (w_vld && ((w_idx_d == '0) || (w_sum > r_max_sum))) begin
            r_max_sum <= w_sum;
            r_max_idx <= w_idx_d;
        end
    end

    assign max_sum = r_max_sum;
    assign max_idx = r_max_idx;

endmodule
`default_nettype wire
